// File: rtl/mac_tx_pkg.sv
// Shared constants, state encoding and the byte-wide CRC-32 step for the MAC transmit path.
package mac_tx_pkg;

    localparam logic [7:0]  C_PREAMBLE    = 8'h55;
    localparam logic [7:0]  C_SFD         = 8'hD5;
    localparam int          C_MIN_PAYLOAD = 46;
    localparam logic [31:0] C_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] C_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [15:0] C_ETH_IPV4    = 16'h0800;
    localparam logic [15:0] C_ETH_ARP     = 16'h0806;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

    // One reflected CRC-32 byte step, LSB of the data byte enters first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ C_CRC_POLY) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 register; clr has priority over en. Output is the raw
// running remainder, the caller inverts it to form the FCS.
module crc32_d8
    import mac_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= C_CRC_INIT;
        else if (clr)
            crc <= C_CRC_INIT;
        else if (en)
            crc <= crc32_byte(crc, data);
    end

endmodule

// File: rtl/mac_tx.sv
// Ethernet transmit framer: buffers payload while preamble and header go out, then
// emits payload, zero pad, FCS and the inter-frame gap on a GMII-style byte stream.
module mac_tx
    import mac_tx_pkg::*;
#(
    parameter logic [47:0] P_SOURCE_MAC = 48'h00_0A_35_01_FE_C0,
    parameter int          P_IFG        = 12,
    parameter int          P_FIFO_DEPTH = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] i_target_mac,
    input  logic        i_target_valid,
    input  logic [47:0] i_source_mac,
    input  logic        i_source_valid,
    input  logic [15:0] i_send_type,
    input  logic [15:0] i_send_len,
    input  logic [7:0]  i_send_data,
    input  logic        i_send_last,
    input  logic        i_send_valid,
    output logic        o_send_ready,
    output logic [7:0]  o_gmii_data,
    output logic        o_gmii_valid,
    output logic        o_len_err,
    output logic        o_drop
);

    localparam int AW = $clog2(P_FIFO_DEPTH);

    state_t        state;
    logic [47:0]   target_mac, source_mac;
    logic [111:0]  hdr_sr;
    logic [15:0]   cnt, len_q;
    logic [10:0]   pay_cnt, pay_nxt;
    logic          frame_open, discard;
    logic [8:0]    mem [P_FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [8:0]    rd_entry;
    logic          fifo_empty, fifo_full, start, underrun, pop, wr_req, wr_en;
    logic [31:0]   crc, fcs;
    logic          crc_en;
    logic [7:0]    crc_byte;

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // frame_open also gates ready so beats discarded after an underrun never open a frame
    assign o_send_ready = (state == S_IDLE) && fifo_empty && !frame_open;
    assign start        = i_send_valid && o_send_ready;
    assign underrun     = (state == S_PAY) && fifo_empty;
    assign pop          = (state == S_PAY) && !fifo_empty;
    assign wr_req       = i_send_valid && (start || (frame_open && !discard && !underrun));
    assign wr_en        = wr_req && !fifo_full;
    assign rd_entry     = mem[rd_ptr[AW-1:0]];
    assign pay_nxt      = (pay_cnt == 11'h7FF) ? pay_cnt : pay_cnt + 11'd1;
    assign fcs          = ~crc;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            target_mac <= 48'hFF_FF_FF_FF_FF_FF;
            source_mac <= P_SOURCE_MAC;
        end else begin
            if (i_target_valid) target_mac <= i_target_mac;
            if (i_source_valid) source_mac <= i_source_mac;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {i_send_last, i_send_data};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Upstream-side frame tracking, independent of how far the wire side has got.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            frame_open <= 1'b0;
            discard    <= 1'b0;
        end else if (start) begin
            frame_open <= !i_send_last;
            discard    <= 1'b0;
        end else if (i_send_valid && frame_open && i_send_last) begin
            frame_open <= 1'b0;
            discard    <= 1'b0;
        end else if (underrun && frame_open) begin
            discard    <= 1'b1;
        end
    end

    always_comb begin
        crc_byte = 8'h00;
        crc_en   = 1'b0;
        case (state)
            S_HDR: begin crc_byte = hdr_sr[111:104]; crc_en = 1'b1; end
            S_PAY: begin crc_byte = rd_entry[7:0];   crc_en = !fifo_empty; end
            S_PAD: crc_en = 1'b1;
            default: ;
        endcase
    end

    crc32_d8 u_crc (
        .clk   (i_clk),
        .rst_n (i_rst),
        .clr   (start),
        .en    (crc_en),
        .data  (crc_byte),
        .crc   (crc)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            len_q        <= '0;
            pay_cnt      <= '0;
            hdr_sr       <= '0;
            o_gmii_data  <= '0;
            o_gmii_valid <= 1'b0;
            o_len_err    <= 1'b0;
            o_drop       <= 1'b0;
        end else begin
            o_len_err <= 1'b0;
            o_drop    <= (i_send_valid && !start && !frame_open) || (wr_req && fifo_full);
            case (state)
                S_IDLE: begin
                    o_gmii_valid <= 1'b0;
                    o_gmii_data  <= 8'h00;
                    if (start) begin
                        state        <= S_PRE;
                        cnt          <= 16'd1;
                        len_q        <= i_send_len;
                        pay_cnt      <= '0;
                        hdr_sr       <= {target_mac, source_mac, i_send_type};
                        o_gmii_valid <= 1'b1;
                        o_gmii_data  <= C_PREAMBLE;
                    end
                end
                S_PRE: begin
                    o_gmii_data <= (cnt == 16'd7) ? C_SFD : C_PREAMBLE;
                    cnt         <= (cnt == 16'd7) ? 16'd0 : cnt + 16'd1;
                    if (cnt == 16'd7) state <= S_HDR;
                end
                S_HDR: begin
                    o_gmii_data <= hdr_sr[111:104];
                    hdr_sr      <= {hdr_sr[103:0], 8'h00};
                    cnt         <= (cnt == 16'd13) ? 16'd0 : cnt + 16'd1;
                    if (cnt == 16'd13) state <= S_PAY;
                end
                S_PAY: begin
                    if (fifo_empty) begin
                        // underrun: abandon the frame without an FCS
                        o_gmii_valid <= 1'b0;
                        o_gmii_data  <= 8'h00;
                        o_len_err    <= 1'b1;
                        cnt          <= '0;
                        state        <= S_IFG;
                    end else begin
                        o_gmii_data <= rd_entry[7:0];
                        pay_cnt     <= pay_nxt;
                        if (rd_entry[8]) begin
                            o_len_err <= ({5'd0, pay_nxt} != len_q);
                            cnt       <= '0;
                            state     <= (pay_nxt < 11'(C_MIN_PAYLOAD)) ? S_PAD : S_FCS;
                        end
                    end
                end
                S_PAD: begin
                    o_gmii_data <= 8'h00;
                    pay_cnt     <= pay_nxt;
                    if (pay_nxt >= 11'(C_MIN_PAYLOAD)) state <= S_FCS;
                end
                S_FCS: begin
                    o_gmii_data <= fcs[{cnt[1:0], 3'b000} +: 8];
                    cnt         <= (cnt == 16'd3) ? 16'd0 : cnt + 16'd1;
                    if (cnt == 16'd3) state <= S_IFG;
                end
                S_IFG: begin
                    o_gmii_valid <= 1'b0;
                    o_gmii_data  <= 8'h00;
                    cnt          <= cnt + 16'd1;
                    if (cnt == 16'(P_IFG - 1)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx.sv
// Randomized scoreboard bench for mac_tx: the driver builds each expected wire frame
// from first principles and queues it; a negedge monitor compares what the DUT emits.
module tb_mac_tx;

    localparam int          P_IFG = 12;
    localparam logic [47:0] SRC0  = 48'h00_0A_35_01_FE_C0;

    logic        i_clk = 1'b0, i_rst = 1'b0;
    logic [47:0] i_target_mac = '0, i_source_mac = '0;
    logic        i_target_valid = 1'b0, i_source_valid = 1'b0;
    logic [15:0] i_send_type = '0, i_send_len = '0;
    logic [7:0]  i_send_data = '0;
    logic        i_send_last = 1'b0, i_send_valid = 1'b0;
    logic        o_send_ready, o_gmii_valid, o_len_err, o_drop;
    logic [7:0]  o_gmii_data;

    logic        cclr = 1'b0, cen = 1'b0;
    logic [7:0]  cdata = '0;
    logic [31:0] cout;

    always #5 i_clk = ~i_clk;

    mac_tx #(.P_SOURCE_MAC(SRC0), .P_IFG(P_IFG), .P_FIFO_DEPTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_target_mac(i_target_mac), .i_target_valid(i_target_valid),
        .i_source_mac(i_source_mac), .i_source_valid(i_source_valid),
        .i_send_type(i_send_type), .i_send_len(i_send_len),
        .i_send_data(i_send_data), .i_send_last(i_send_last), .i_send_valid(i_send_valid),
        .o_send_ready(o_send_ready), .o_gmii_data(o_gmii_data), .o_gmii_valid(o_gmii_valid),
        .o_len_err(o_len_err), .o_drop(o_drop)
    );

    crc32_d8 u_crc (.clk(i_clk), .rst_n(i_rst), .clr(cclr), .en(cen), .data(cdata), .crc(cout));

    int          n_cmp = 0, n_err = 0;
    logic [7:0]  exp_q[$];
    int          flen_q[$];
    bit          lerr_q[$];
    bit          gap_q[$];
    logic [31:0] crc_tab [256];
    logic [47:0] m_target, m_source;
    logic [7:0]  pl[$];
    int          exp_drop = 0, drop_seen = 0;
    bit          in_frame = 0, have_prev = 0, ready_hi = 0;
    int          low_run = 0, byte_cnt = 0, lerr_cnt = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Expected wire image: preamble, header, payload, pad to 46, table-driven CRC, FCS LSB first.
    task automatic build_expected(input logic [15:0] et, input logic [15:0] lenf);
        logic [7:0]  f[$];
        logic [31:0] c;
        int          n;
        n = pl.size();
        repeat (7) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < 6; i++) f.push_back(m_target[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(m_source[47-8*i -: 8]);
        f.push_back(et[15:8]);
        f.push_back(et[7:0]);
        for (int i = 0; i < n; i++) f.push_back(pl[i]);
        for (int i = n; i < 46; i++) f.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < f.size(); i++) c = crc_tab[c[7:0] ^ f[i]] ^ (c >> 8);
        c = ~c;
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
        foreach (f[i]) exp_q.push_back(f[i]);
        flen_q.push_back(f.size());
        lerr_q.push_back(((n > 2047) ? 2047 : n) != int'(lenf));
    endtask

    // Sends pl[] as one frame. abort_at>=0 asserts reset instead of that beat.
    task automatic send_frame(input logic [15:0] et, input logic [15:0] lenf, input int abort_at,
                              input bit stray, input bit cfg_mid);
        int n, w;
        bit busy;
        n = pl.size(); w = 0; busy = 0;
        while (!o_send_ready && w < 4000) begin
            busy = 1;
            @(posedge i_clk); #2;
            w++;
        end
        if (!o_send_ready) begin
            chk(0, "ready_timeout", 0, 1);
            return;
        end
        build_expected(et, lenf);
        gap_q.push_back(busy);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                i_send_valid = 0; i_send_last = 0;
                i_rst = 0;
                #1;
                chk(o_gmii_valid == 1'b0, "rst_async_valid", o_gmii_valid, 0);
                chk(o_gmii_data == 8'h00, "rst_async_data", o_gmii_data, 0);
                exp_q.delete(); flen_q.delete(); lerr_q.delete(); gap_q.delete();
                m_target = 48'hFF_FF_FF_FF_FF_FF;
                m_source = SRC0;
                repeat (3) @(posedge i_clk);
                #2 i_rst = 1;
                @(posedge i_clk); #2;
                chk(o_send_ready == 1'b1, "ready_after_rst", o_send_ready, 1);
                return;
            end
            i_send_valid = 1; i_send_data = pl[i]; i_send_last = (i == n - 1);
            i_send_type = et; i_send_len = lenf;
            if (cfg_mid && i == 1) begin
                i_target_valid = 1; i_target_mac = 48'h11_22_33_44_55_66;
                m_target = 48'h11_22_33_44_55_66;
            end
            @(posedge i_clk); #2;
            i_target_valid = 0;
        end
        i_send_valid = 0; i_send_last = 0;
        if (stray) begin
            i_send_valid = 1; i_send_data = 8'hAA;
            @(posedge i_clk); #2;
            i_send_valid = 0;
            exp_drop++;
            chk(o_drop == 1'b1, "drop_pulse", o_drop, 1);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            in_frame = 0; have_prev = 0; low_run = 0; lerr_cnt = 0; ready_hi = 0;
        end else begin
            if (o_drop) drop_seen++;
            if (o_gmii_valid) begin
                if (!in_frame) begin
                    in_frame = 1; byte_cnt = 0; ready_hi = 0; lerr_cnt = 0;
                    if (gap_q.size() > 0) begin
                        if (gap_q.pop_front() && have_prev) chk(low_run == P_IFG, "ifg_len", low_run, P_IFG);
                    end
                end
                if (o_send_ready) ready_hi = 1;
                if (exp_q.size() == 0) chk(0, "unexpected_byte", o_gmii_data, 0);
                else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk(o_gmii_data == e, "wire_byte", o_gmii_data, e);
                end
                byte_cnt++;
            end
            if (o_len_err) lerr_cnt++;
            if (!o_gmii_valid) begin
                if (in_frame) begin
                    in_frame = 0; have_prev = 1; low_run = 1;
                    chk(ready_hi == 0, "ready_low_in_frame", ready_hi, 0);
                    if (flen_q.size() > 0) begin
                        int fl;
                        fl = flen_q.pop_front();
                        chk(byte_cnt == fl, "frame_len", byte_cnt, fl);
                    end else chk(0, "frame_unexpected", byte_cnt, 0);
                    if (lerr_q.size() > 0) begin
                        bit le;
                        le = lerr_q.pop_front();
                        chk(lerr_cnt == int'(le), "len_err_pulses", lerr_cnt, le);
                    end
                end else low_run++;
            end
        end
    end

    initial begin
        string s;
        int    w;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = i;
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
        m_target = 48'hFF_FF_FF_FF_FF_FF;
        m_source = SRC0;

        repeat (3) @(posedge i_clk);
        #2;
        chk(o_send_ready == 1'b1, "rst_ready", o_send_ready, 1);
        chk(o_gmii_valid == 1'b0, "rst_valid", o_gmii_valid, 0);
        chk(o_gmii_data == 8'h00, "rst_data", o_gmii_data, 0);
        chk(o_len_err == 1'b0, "rst_len_err", o_len_err, 0);
        chk(o_drop == 1'b0, "rst_drop", o_drop, 0);
        i_rst = 1;
        @(posedge i_clk); #2;

        cclr = 1; @(posedge i_clk); #2; cclr = 0;
        s = "123456789";
        for (int i = 0; i < 9; i++) begin
            cen = 1; cdata = s[i];
            @(posedge i_clk); #2;
        end
        cen = 0;
        chk(~cout == 32'hCBF43926, "crc_check_value", ~cout, 32'hCBF43926);

        pl.delete(); pl.push_back(8'h01); pl.push_back(8'h02);
        send_frame(16'h0800, 16'd2, -1, 0, 0);

        pl.delete();
        for (int i = 0; i < 1500; i++) pl.push_back(8'(i));
        send_frame(16'h0800, 16'd1500, -1, 0, 0);

        pl.delete(); pl.push_back(8'h10); pl.push_back(8'h20);
        send_frame(16'h0806, 16'd3, -1, 0, 0);

        pl.delete(); pl.push_back(8'hA1); pl.push_back(8'hA2);
        send_frame(16'h0800, 16'd2, -1, 1, 1);
        pl.delete(); pl.push_back(8'hB1); pl.push_back(8'hB2); pl.push_back(8'hB3);
        send_frame(16'h0806, 16'd3, -1, 0, 0);

        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'($urandom));
        send_frame(16'h0800, 16'd100, 40, 0, 0);
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        send_frame(16'h0800, 16'd10, -1, 0, 0);

        for (int f = 0; f < 12; f++) begin
            int          n;
            logic [15:0] et, lenf;
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(47, 300) : $urandom_range(1, 60);
            et = ($urandom_range(0, 1) == 0) ? 16'h0800 : 16'($urandom);
            lenf = ($urandom_range(0, 3) == 0) ? 16'(n + 1) : 16'(n);
            if ($urandom_range(0, 3) == 0) begin
                logic [47:0] sm;
                sm = {16'($urandom), 32'($urandom)};
                i_source_valid = 1; i_source_mac = sm; m_source = sm;
                @(posedge i_clk); #2;
                i_source_valid = 0;
            end
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            send_frame(et, lenf, -1, ($urandom_range(0, 3) == 0), 0);
        end

        w = 0;
        while ((exp_q.size() > 0 || in_frame) && w < 5000) begin
            @(posedge i_clk); #2;
            w++;
        end
        repeat (P_IFG + 4) @(posedge i_clk);
        #2;
        chk(exp_q.size() == 0, "drain_bytes_left", exp_q.size(), 0);
        chk(drop_seen == exp_drop, "drop_count", drop_seen, exp_drop);
        chk(o_send_ready == 1'b1, "final_ready", o_send_ready, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
